// File: rtl/simple_bus_arbiter.sv
// simple_bus_arbiter: round-robin arbiter sharing one simple_bus slave among
// N_MASTERS requesters. A grant is held from selection through start and
// until the slave reports rdy (or until the master drops req before starting).
// Optional feature macro: SIMPLE_BUS_ARB_TIMEOUT_EN revokes a grant that is
// held for TIMEOUT cycles without a start and pulses timeout_err.
module simple_bus_arbiter #(
  parameter int N_MASTERS = 4,
  parameter int TIMEOUT   = 16,
  parameter int GW        = $clog2(N_MASTERS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_MASTERS-1:0]   m_req,
  output logic [N_MASTERS-1:0]   m_gnt,
  input  logic [8*N_MASTERS-1:0] m_addr,
  input  logic [2*N_MASTERS-1:0] m_mode,
  input  logic [N_MASTERS-1:0]   m_start,
  input  logic [8*N_MASTERS-1:0] m_wdata,
  output logic [N_MASTERS-1:0]   m_rdy,
  output logic [7:0]             m_rdata,
  output logic                   s_req,
  output logic [7:0]             s_addr,
  output logic [1:0]             s_mode,
  output logic                   s_start,
  output logic [7:0]             s_wdata,
  input  logic [7:0]             s_rdata,
  input  logic                   s_rdy,
  output logic                   timeout_err
);

  typedef enum logic [1:0] {IDLE, GRANT, BUSY} state_t;

  state_t               state;
  logic [GW-1:0]        g;
  logic [GW-1:0]        last;
  logic [GW-1:0]        pick;
  logic [N_MASTERS-1:0] pick_onehot;
  logic                 any_req;
  logic                 found;
  logic                 req_g;
  logic                 start_g;
  logic [7:0]           sel_addr;
  logic [1:0]           sel_mode;
  logic [7:0]           sel_wdata;

  // Reject parameter values outside the supported range at elaboration time.
  if (N_MASTERS < 2 || N_MASTERS > 8 || TIMEOUT < 1 || TIMEOUT > 255) begin : g_param_check
    $error("simple_bus_arbiter: N_MASTERS must be 2..8 and TIMEOUT 1..255");
  end

  // Pick the first requester strictly after the last released master, wrapping around.
  always_comb begin
    pick    = last;
    found   = 1'b0;
    any_req = |m_req;
    for (int i = 1; i <= N_MASTERS; i++) begin
      for (int j = 0; j < N_MASTERS; j++) begin
        if (!found && m_req[j] && (j == (int'(last) + i) % N_MASTERS)) begin
          found = 1'b1;
          pick  = GW'(j);
        end
      end
    end
  end

  // One-hot form of the pick, loaded into m_gnt when a grant is issued.
  always_comb begin
    pick_onehot = '0;
    for (int j = 0; j < N_MASTERS; j++) begin
      pick_onehot[j] = (int'(pick) == j);
    end
  end

  // Select the granted master's request, start and bus fields.
  always_comb begin
    req_g     = 1'b0;
    start_g   = 1'b0;
    sel_addr  = '0;
    sel_mode  = '0;
    sel_wdata = '0;
    for (int j = 0; j < N_MASTERS; j++) begin
      if (int'(g) == j) begin
        req_g     = m_req[j];
        start_g   = m_start[j];
        sel_addr  = m_addr[8*j +: 8];
        sel_mode  = m_mode[2*j +: 2];
        sel_wdata = m_wdata[8*j +: 8];
      end
    end
  end

  // Drive the slave side only while a master owns the bus; rdy goes back to the owner alone.
  always_comb begin
    s_req   = 1'b0;
    s_addr  = '0;
    s_mode  = '0;
    s_start = 1'b0;
    s_wdata = '0;
    m_rdata = s_rdata;
    m_rdy   = '0;
    if (state != IDLE) begin
      s_req   = (state == BUSY) ? 1'b1 : req_g;
      s_addr  = sel_addr;
      s_mode  = sel_mode;
      s_start = start_g;
      s_wdata = sel_wdata;
    end
    for (int j = 0; j < N_MASTERS; j++) begin
      m_rdy[j] = (state == BUSY) && (int'(g) == j) && s_rdy;
    end
  end

`ifdef SIMPLE_BUS_ARB_TIMEOUT_EN
  logic [7:0] to_cnt;

  // Arbitration FSM with grant timeout: start beats timeout, and only GRANT is timed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      g           <= '0;
      last        <= GW'(N_MASTERS - 1);
      m_gnt       <= '0;
      to_cnt      <= '0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            g      <= pick;
            m_gnt  <= pick_onehot;
            to_cnt <= '0;
            state  <= GRANT;
          end
        end
        GRANT: begin
          if (start_g) begin
            state <= BUSY;
          end else if (!req_g) begin
            last  <= g;
            m_gnt <= '0;
            state <= IDLE;
          end else if (to_cnt == 8'(TIMEOUT - 1)) begin
            last        <= g;
            m_gnt       <= '0;
            timeout_err <= 1'b1;
            state       <= IDLE;
          end else begin
            to_cnt <= to_cnt + 8'd1;
          end
        end
        BUSY: begin
          if (s_rdy) begin
            last  <= g;
            m_gnt <= '0;
            state <= IDLE;
          end
        end
        default: begin
          m_gnt <= '0;
          state <= IDLE;
        end
      endcase
    end
  end
`else
  assign timeout_err = 1'b0;

  // Arbitration FSM: a grant is held until start, or until the master drops req first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      g     <= '0;
      last  <= GW'(N_MASTERS - 1);
      m_gnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            g     <= pick;
            m_gnt <= pick_onehot;
            state <= GRANT;
          end
        end
        GRANT: begin
          if (start_g) begin
            state <= BUSY;
          end else if (!req_g) begin
            last  <= g;
            m_gnt <= '0;
            state <= IDLE;
          end
        end
        BUSY: begin
          if (s_rdy) begin
            last  <= g;
            m_gnt <= '0;
            state <= IDLE;
          end
        end
        default: begin
          m_gnt <= '0;
          state <= IDLE;
        end
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_simple_bus_arbiter.sv
// tb_simple_bus_arbiter: directed scenarios plus randomized transactions for
// simple_bus_arbiter (4 masters, TIMEOUT=4). Honours SIMPLE_BUS_ARB_TIMEOUT_EN.
module tb_simple_bus_arbiter;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] m_req;
  logic [N-1:0] m_gnt;
  logic [8*N-1:0] m_addr;
  logic [2*N-1:0] m_mode;
  logic [N-1:0] m_start;
  logic [8*N-1:0] m_wdata;
  logic [N-1:0] m_rdy;
  logic [7:0]   m_rdata;
  logic         s_req;
  logic [7:0]   s_addr;
  logic [1:0]   s_mode;
  logic         s_start;
  logic [7:0]   s_wdata;
  logic [7:0]   s_rdata;
  logic         s_rdy;
  logic         timeout_err;

  int checks = 0;
  int passes = 0;

  simple_bus_arbiter #(.N_MASTERS(N), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .m_req(m_req), .m_gnt(m_gnt), .m_addr(m_addr), .m_mode(m_mode),
    .m_start(m_start), .m_wdata(m_wdata), .m_rdy(m_rdy), .m_rdata(m_rdata),
    .s_req(s_req), .s_addr(s_addr), .s_mode(s_mode), .s_start(s_start),
    .s_wdata(s_wdata), .s_rdata(s_rdata), .s_rdy(s_rdy),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // Advance one clock and settle just after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    m_req = '0; m_start = '0; m_addr = '0; m_mode = '0; m_wdata = '0;
    s_rdata = '0; s_rdy = 1'b0;
  endtask

  task automatic pulse_reset();
    clear_inputs();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    #2;
    checks++; if (m_gnt !== 4'b0000) $display("[TB] FAIL reset_gnt: got %b want 0000", m_gnt); else passes++;
    checks++; if ({s_req, s_start, s_addr, s_mode, s_wdata} !== 20'h0) $display("[TB] FAIL reset_slave: got %h want 0", {s_req, s_start, s_addr, s_mode, s_wdata}); else passes++;
    checks++; if ({m_rdy, timeout_err} !== 5'b0) $display("[TB] FAIL reset_rdy_err: got %b want 00000", {m_rdy, timeout_err}); else passes++;
    step();
    rst = 1'b0;
  endtask

  task automatic test_single();
    step();
    m_req = 4'b0001;
    #1;
    checks++; if (m_gnt !== 4'b0000) $display("[TB] FAIL single_latency: got %b want 0000", m_gnt); else passes++;
    step();
    checks++; if (m_gnt !== 4'b0001) $display("[TB] FAIL single_gnt: got %b want 0001", m_gnt); else passes++;
    m_start = 4'b0001; m_addr[7:0] = 8'h3C; m_mode[1:0] = 2'b10; m_wdata[7:0] = 8'hA5;
    #1;
    checks++; if ({s_addr, s_start, s_mode, s_wdata} !== {8'h3C, 1'b1, 2'b10, 8'hA5}) $display("[TB] FAIL single_mux: got %h/%b/%b/%h want 3c/1/10/a5", s_addr, s_start, s_mode, s_wdata); else passes++;
    step();
    m_start = '0;
    s_rdy = 1'b1; s_rdata = 8'h5A;
    #1;
    checks++; if (m_rdy !== 4'b0001) $display("[TB] FAIL single_rdy: got %b want 0001", m_rdy); else passes++;
    checks++; if (m_rdata !== 8'h5A) $display("[TB] FAIL single_rdata: got %h want 5a", m_rdata); else passes++;
    step();
    s_rdy = 1'b0; m_req = '0;
    checks++; if (m_gnt !== 4'b0000) $display("[TB] FAIL single_release: got %b want 0000", m_gnt); else passes++;
  endtask

  task automatic test_round_robin();
    int exp_m = 0;
    pulse_reset();
    m_req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      step();
      checks++; if (m_gnt !== 4'(1 << exp_m)) $display("[TB] FAIL rr_order_%0d: got %b want %b", k, m_gnt, 4'(1 << exp_m)); else passes++;
      m_start = 4'(1 << exp_m);
      step();
      m_start = '0;
      step();
      s_rdy = 1'b1;
      step();
      s_rdy = 1'b0;
      checks++; if (m_gnt !== 4'b0000) $display("[TB] FAIL rr_idle_gap_%0d: got %b want 0000", k, m_gnt); else passes++;
      exp_m = (exp_m + 1) % N;
    end
    m_req = '0;
    step();
  endtask

  task automatic test_no_preempt();
    int bad = 0;
    pulse_reset();
    m_req = 4'b0100;
    step();
    checks++; if (m_gnt !== 4'b0100) $display("[TB] FAIL nopre_gnt: got %b want 0100", m_gnt); else passes++;
    m_start = 4'b0100;
    step();
    m_start = '0;
    m_req = 4'b0110;
    for (int k = 0; k < 3; k++) begin
      step();
      if (m_gnt !== 4'b0100) bad++;
    end
    checks++; if (bad != 0) $display("[TB] FAIL nopre_hold: got %0d bad cycles want 0", bad); else passes++;
    s_rdy = 1'b1;
    step();
    s_rdy = 1'b0; m_req = 4'b0010;
    checks++; if (m_gnt !== 4'b0000) $display("[TB] FAIL nopre_idle: got %b want 0000", m_gnt); else passes++;
    step();
    checks++; if (m_gnt !== 4'b0010) $display("[TB] FAIL nopre_next: got %b want 0010", m_gnt); else passes++;
  endtask

  // Continues with master 1 granted from test_no_preempt.
  task automatic test_drop_req();
    s_rdy = 1'b1;
    #1;
    checks++; if (m_rdy !== 4'b0000) $display("[TB] FAIL drop_rdy_in_grant: got %b want 0000", m_rdy); else passes++;
    step();
    s_rdy = 1'b0;
    checks++; if (m_gnt !== 4'b0010) $display("[TB] FAIL drop_rdy_ignored: got %b want 0010", m_gnt); else passes++;
    m_req = '0;
    step();
    checks++; if (m_gnt !== 4'b0000) $display("[TB] FAIL drop_release: got %b want 0000", m_gnt); else passes++;
  endtask

  task automatic test_timeout();
    int bad = 0;
    pulse_reset();
    m_req = 4'b0011;
    step();
    checks++; if (m_gnt !== 4'b0001) $display("[TB] FAIL to_gnt0: got %b want 0001", m_gnt); else passes++;
`ifdef SIMPLE_BUS_ARB_TIMEOUT_EN
    for (int k = 0; k < 3; k++) begin
      step();
      if (m_gnt !== 4'b0001 || timeout_err !== 1'b0) bad++;
    end
    checks++; if (bad != 0) $display("[TB] FAIL to_hold: got %0d bad cycles want 0", bad); else passes++;
    step();
    checks++; if ({m_gnt, timeout_err} !== 5'b00001) $display("[TB] FAIL to_revoke: got %b want 00001", {m_gnt, timeout_err}); else passes++;
    step();
    checks++; if ({m_gnt, timeout_err} !== 5'b00100) $display("[TB] FAIL to_next: got %b want 00100", {m_gnt, timeout_err}); else passes++;
`else
    for (int k = 0; k < 120; k++) begin
      step();
      if (m_gnt !== 4'b0001 || timeout_err !== 1'b0) bad++;
    end
    checks++; if (bad != 0) $display("[TB] FAIL to_held_forever: got %0d bad cycles want 0", bad); else passes++;
`endif
    m_req = '0;
    step();
  endtask

  task automatic test_reset_busy();
    pulse_reset();
    m_req = 4'b0010;
    step();
    m_start = 4'b0010;
    step();
    s_rdy = 1'b1;
    #1;
    checks++; if ({m_rdy, s_start, s_req} !== 6'b001011) $display("[TB] FAIL rstbusy_pre: got %b want 001011", {m_rdy, s_start, s_req}); else passes++;
    rst = 1'b1;
    #1;
    checks++; if ({m_gnt, m_rdy, s_start, s_req} !== 10'b0) $display("[TB] FAIL rstbusy_drop: got %b want 0", {m_gnt, m_rdy, s_start, s_req}); else passes++;
    clear_inputs();
    step();
    rst = 1'b0;
    m_req = 4'b1000;
    step();
    checks++; if (m_gnt !== 4'b1000) $display("[TB] FAIL rstbusy_m3: got %b want 1000", m_gnt); else passes++;
    m_req = '0;
    step();
  endtask

  // Random transactions predicted at transaction level: winner = first requester after last owner.
  task automatic test_random();
    int last_m = N - 1;
    int w, d, k;
    logic [N-1:0] mask;
    logic [7:0] rd;
    pulse_reset();
    for (int t = 0; t < 30; t++) begin
      mask = N'($urandom_range(1, 15));
      w = -1;
      for (int i = 1; i <= N; i++) begin
        k = (last_m + i) % N;
        if (w < 0 && ((mask >> k) & 4'd1) != 0) w = k;
      end
      m_req = mask; m_addr = $urandom; m_wdata = $urandom; m_mode = 8'($urandom);
      step();
      checks++; if (m_gnt !== 4'(1 << w)) $display("[TB] FAIL rnd_gnt_%0d: got %b want %b", t, m_gnt, 4'(1 << w)); else passes++;
      if ($urandom_range(0, 3) == 0) begin
        m_req = '0;
        step();
        checks++; if (m_gnt !== 4'b0000) $display("[TB] FAIL rnd_drop_%0d: got %b want 0000", t, m_gnt); else passes++;
      end else begin
        m_start = 4'(1 << w);
        if ($urandom_range(0, 1) == 1) m_req = mask & ~4'(1 << w);
        #1;
        checks++; if ({s_addr, s_mode, s_wdata, s_start} !== {m_addr[8*w +: 8], m_mode[2*w +: 2], m_wdata[8*w +: 8], 1'b1})
          $display("[TB] FAIL rnd_mux_%0d: got %h/%b/%h/%b want %h/%b/%h/1", t, s_addr, s_mode, s_wdata, s_start, m_addr[8*w +: 8], m_mode[2*w +: 2], m_wdata[8*w +: 8]);
        else passes++;
        step();
        m_start = '0;
        m_req = N'($urandom);
        d = $urandom_range(0, 3);
        for (int c = 0; c < d; c++) begin
          #1;
          checks++; if ({m_gnt, m_rdy, s_req} !== {4'(1 << w), 4'b0000, 1'b1}) $display("[TB] FAIL rnd_busy_%0d: got %b want %b", t, {m_gnt, m_rdy, s_req}, {4'(1 << w), 4'b0000, 1'b1}); else passes++;
          step();
        end
        rd = 8'($urandom);
        s_rdy = 1'b1; s_rdata = rd;
        if ($urandom_range(0, 1) == 1) m_start = 4'(1 << w);
        #1;
        checks++; if ({m_rdy, m_rdata} !== {4'(1 << w), rd}) $display("[TB] FAIL rnd_rdy_%0d: got %b/%h want %b/%h", t, m_rdy, m_rdata, 4'(1 << w), rd); else passes++;
        step();
        s_rdy = 1'b0; m_req = '0; m_start = '0;
        checks++; if (m_gnt !== 4'b0000) $display("[TB] FAIL rnd_done_%0d: got %b want 0000", t, m_gnt); else passes++;
      end
      last_m = w;
      step();
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_no_preempt();
    test_drop_req();
    test_timeout();
    test_reset_busy();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
